// File: rtl/debug_uart_tx_arbiter_if.sv
// Byte-source, UART-handshake and status signals of the debug UART TX arbiter.
// master = bus/trace/uart side, slave = arbiter.
interface debug_uart_tx_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          s0_valid;
  logic [7:0]    s0_data;
  logic          s0_full;
  logic          s1_valid;
  logic [7:0]    s1_data;
  logic          s1_ready;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          status_busy;
  logic          overflow;
  logic          overflow_clr;
  logic [LW-1:0] s0_level;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, tx_busy, overflow_clr,
    input  s0_full, s1_ready, tx_en, tx_data, status_busy, overflow, s0_level
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, tx_busy, overflow_clr,
    output s0_full, s1_ready, tx_en, tx_data, status_busy, overflow, s0_level
  );
endinterface

// File: rtl/debug_uart_tx_arbiter.sv
// Round-robin arbiter draining two byte FIFOs (CPU writes, trace stream) into
// the single debug uart_tx start/busy handshake.
module debug_uart_tx_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] r_mem;
  logic [AW:0]           r_wp, r_rp;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign o_data  = r_mem[r_rp[AW-1:0]];
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_level = r_wp - r_rp;
endmodule

module debug_uart_tx_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  debug_uart_tx_arbiter_if.slave bus
);
  localparam int NSRC = 2;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CW   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                     r_state, w_next;
  logic                       r_ptr, w_ptr_nxt;
  logic                       r_src;
  logic                       w_gnt, w_grant;
  logic [CW-1:0]              r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]                 r_tx_data;
  logic                       r_ovf;
  logic                       w_tx_en;

  logic [NSRC-1:0]            w_push, w_pop, w_full, w_empty;
  logic [NSRC-1:0][7:0]       w_din, w_head;
  logic [NSRC-1:0][LW-1:0]    w_lvl;

  assign w_din[0]  = bus.s0_data;
  assign w_din[1]  = bus.s1_data;
  // A pop in the same cycle frees a slot, so a full s0 FIFO still accepts.
  assign w_push[0] = bus.s0_valid && (!w_full[0] || w_pop[0]);
  assign w_push[1] = bus.s1_valid && !w_full[1];

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    debug_uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_data  (w_din[g]),
      .i_pop   (w_pop[g]),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_level (w_lvl[g])
    );
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next    = r_state;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_gnt     = r_ptr;
    w_grant   = 1'b0;
    w_pop     = '0;
    w_tx_en   = 1'b0;
    case (r_state)
      IDLE: begin
        // A busy line held by another user blocks any new grant.
        if (!bus.tx_busy && !(&w_empty)) begin
          w_gnt        = (w_empty == 2'b00) ? r_ptr : w_empty[0];
          w_grant      = 1'b1;
          w_pop[w_gnt] = 1'b1;
          w_next       = START;
        end
      end
      START: begin
        w_tx_en   = 1'b1;
        w_cnt_nxt = '0;
        w_next    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_next = WAIT_DONE;
        end else if (w_cnt_inc == CW'(BUSY_TIMEOUT)) begin
          w_next    = IDLE;
          w_ptr_nxt = ~r_src;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_next    = IDLE;
          w_ptr_nxt = ~r_src;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_src     <= 1'b0;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) begin
        r_src     <= w_gnt;
        r_tx_data <= w_head[w_gnt];
      end
      if (bus.s0_valid && w_full[0] && !w_pop[0]) r_ovf <= 1'b1;
      else if (bus.overflow_clr)                  r_ovf <= 1'b0;
    end
  end

  assign bus.tx_en       = w_tx_en;
  assign bus.tx_data     = r_tx_data;
  assign bus.s0_full     = w_full[0];
  assign bus.s1_ready    = !w_full[1];
  assign bus.s0_level    = w_lvl[0];
  assign bus.overflow    = r_ovf;
  assign bus.status_busy = (r_state != IDLE) || (|w_lvl);
endmodule

// File: tb/tb_debug_uart_tx_arbiter.sv
// Randomized and directed bench for debug_uart_tx_arbiter with a queue-based
// transfer-timeline model checked every cycle.
module tb_debug_uart_tx_arbiter;
  localparam int D  = 4;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_uart_tx_arbiter_if #(.FIFO_DEPTH(D)) bus();
  debug_uart_tx_arbiter #(.FIFO_DEPTH(D), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // UART stand-in: busy for blen cycles, starting bdly cycles after a start pulse.
  int blen = 0, bdly = 0, dly = 0, rem = 0;
  bit hold = 0, en_lat = 0, acc_lat = 0;
  int nr_cnt = 0;
  logic [7:0] obs[$];
  int obs_c[$];

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      dly = 0; rem = 0; bus.tx_busy = 1'b0;
    end else if (hold) begin
      bus.tx_busy = 1'b1;
    end else begin
      if (en_lat && blen > 0) begin dly = bdly; rem = blen; end
      if (dly > 0) begin dly--; bus.tx_busy = 1'b0; end
      else if (rem > 0) begin rem--; bus.tx_busy = 1'b1; end
      else bus.tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    en_lat  = rst_n && bus.tx_en;
    acc_lat = bus.s1_valid && bus.s1_ready;
    if (rst_n && bus.s1_valid && !bus.s1_ready) nr_cnt++;
    if (rst_n && bus.tx_en) begin
      obs.push_back(bus.tx_data);
      obs_c.push_back(cyc);
    end
  end

  // Model: per-source byte queues plus a transfer timeline measured in cycles
  // since the grant (age 1 = start pulse, age>=2 = waiting on the UART).
  logic [7:0] q0[$], q1[$];
  logic [7:0] m_txd;
  bit m_ovf, m_ptr, m_act, m_rose, m_src;
  int m_age;

  always @(negedge clk) begin
    int sz0, sz1;
    bit p0, s;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_txd = 8'h00; m_ovf = 0; m_ptr = 0; m_act = 0; m_rose = 0; m_src = 0; m_age = 0;
    end else begin
      sz0 = q0.size(); sz1 = q1.size();
      chk("tx_en", int'(bus.tx_en), int'(m_act && m_age == 1));
      chk("tx_data", int'(bus.tx_data), int'(m_txd));
      chk("s0_full", int'(bus.s0_full), int'(sz0 == D));
      chk("s1_ready", int'(bus.s1_ready), int'(sz1 < D));
      chk("s0_level", int'(bus.s0_level), sz0);
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("status_busy", int'(bus.status_busy), int'(m_act || sz0 > 0 || sz1 > 0));
      p0 = 0;
      if (!m_act) begin
        if (!bus.tx_busy && (sz0 > 0 || sz1 > 0)) begin
          s = (sz0 > 0 && sz1 > 0) ? m_ptr : (sz0 == 0);
          if (!s) begin m_txd = q0.pop_front(); p0 = 1; end
          else m_txd = q1.pop_front();
          m_src = s; m_act = 1; m_age = 1; m_rose = 0;
        end
      end else begin
        if (m_age >= 2) begin
          if (!m_rose) begin
            if (bus.tx_busy) m_rose = 1;
            else if (m_age - 1 == TO) begin m_act = 0; m_ptr = !m_src; end
          end else if (!bus.tx_busy) begin
            m_act = 0; m_ptr = !m_src;
          end
        end
        m_age++;
      end
      if (bus.overflow_clr) m_ovf = 0;
      if (bus.s0_valid) begin
        if (sz0 < D || p0) q0.push_back(bus.s0_data);
        else m_ovf = 1;
      end
      if (bus.s1_valid && sz1 < D) q1.push_back(bus.s1_data);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle_inputs();
    bus.s0_valid = 0; bus.s0_data = 0; bus.s1_valid = 0; bus.s1_data = 0;
    bus.overflow_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs(); hold = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic s0_wr(input logic [7:0] d);
    bus.s0_valid = 1; bus.s0_data = d; tick(); bus.s0_valid = 0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && (bus.status_busy || bus.tx_busy); i++) tick();
    chk("drain", int'(bus.status_busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, ob, idx, nr0;
    idle_inputs();
    repeat (2) tick();
    chk("rst_tx_en", int'(bus.tx_en), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_s0_full", int'(bus.s0_full), 0);
    chk("rst_s1_ready", int'(bus.s1_ready), 1);
    chk("rst_status", int'(bus.status_busy), 0);
    chk("rst_level", int'(bus.s0_level), 0);

    // Single CPU byte
    do_reset(); blen = 10; bdly = 0; ob = obs.size(); w = cyc;
    s0_wr(8'h41);
    while (cyc < w + 13) tick();
    chk("single_busy_held", int'(bus.status_busy), 1);
    tick();
    chk("single_busy_fall", int'(bus.status_busy), 0);
    wait_idle(100);
    chk("single_count", obs.size() - ob, 1);
    if (obs.size() > ob) begin
      chk("single_data", int'(obs[ob]), 'h41);
      chk("single_latency", obs_c[ob] - w, 2);
    end

    // Round-robin
    do_reset(); hold = 1; tick(); ob = obs.size();
    bus.s0_valid = 1; bus.s0_data = 8'h10; bus.s1_valid = 1; bus.s1_data = 8'h20; tick();
    bus.s0_data = 8'h11; bus.s1_data = 8'h21; tick();
    idle_inputs(); blen = 3; hold = 0;
    wait_idle(200);
    chk("rr_count", obs.size() - ob, 4);
    if (obs.size() >= ob + 4) begin
      chk("rr_0", int'(obs[ob]), 'h10);
      chk("rr_1", int'(obs[ob+1]), 'h20);
      chk("rr_2", int'(obs[ob+2]), 'h11);
      chk("rr_3", int'(obs[ob+3]), 'h21);
    end

    // Overflow
    do_reset(); hold = 1; tick(); ob = obs.size();
    for (int i = 1; i <= 5; i++) begin
      s0_wr(8'(i));
      if (i == 4) begin
        chk("ovf_full4", int'(bus.s0_full), 1);
        chk("ovf_not_yet", int'(bus.overflow), 0);
      end
    end
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_level", int'(bus.s0_level), 4);
    bus.overflow_clr = 1; tick(); bus.overflow_clr = 0;
    chk("ovf_clr", int'(bus.overflow), 0);
    blen = 2; hold = 0;
    wait_idle(200);
    chk("ovf_count", obs.size() - ob, 4);
    for (int i = 0; i < 4 && ob + i < obs.size(); i++) chk("ovf_data", int'(obs[ob+i]), i + 1);

    // Backpressure on source 1
    do_reset(); blen = 6; bdly = 0; ob = obs.size(); nr0 = nr_cnt; idx = 0;
    bus.s1_valid = 1; bus.s1_data = 8'h30;
    for (int c = 0; c < 400 && idx < 8; c++) begin
      tick();
      if (acc_lat) idx++;
      if (idx < 8) bus.s1_data = 8'(8'h30 + idx);
      else bus.s1_valid = 0;
    end
    bus.s1_valid = 0;
    chk("bp_accepted", idx, 8);
    wait_idle(400);
    chk("bp_saw_not_ready", int'(nr_cnt > nr0), 1);
    chk("bp_count", obs.size() - ob, 8);
    for (int i = 0; i < 8 && ob + i < obs.size(); i++) chk("bp_order", int'(obs[ob+i]), 'h30 + i);

    // Busy timeout
    do_reset(); blen = 0; ob = obs.size();
    for (int i = 0; i < 4; i++) s0_wr(8'(8'h50 + i));
    wait_idle(200);
    chk("to_count", obs.size() - ob, 4);
    for (int i = 1; i < 4 && ob + i < obs.size(); i++) chk("to_period", obs_c[ob+i] - obs_c[ob+i-1], 5);

    // Reset mid-transfer (in WAIT_DONE with two bytes queued)
    do_reset(); blen = 10; bdly = 0; ob = obs.size(); w = cyc;
    s0_wr(8'hA0); s0_wr(8'hA1); s0_wr(8'hA2);
    while (cyc < w + 6) tick();
    chk("mid_level", int'(bus.s0_level), 2);
    chk("mid_sent", obs.size() - ob, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_tx_en", int'(bus.tx_en), 0);
    chk("mid_tx_data", int'(bus.tx_data), 0);
    chk("mid_overflow", int'(bus.overflow), 0);
    chk("mid_s0_full", int'(bus.s0_full), 0);
    chk("mid_s1_ready", int'(bus.s1_ready), 1);
    chk("mid_status", int'(bus.status_busy), 0);
    chk("mid_level0", int'(bus.s0_level), 0);
    tick(); tick(); rst_n = 1; ob = obs.size();
    repeat (20) tick();
    chk("mid_no_tx", obs.size() - ob, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        blen = $urandom_range(0, 12);
        bdly = $urandom_range(0, 5);
        hold = ($urandom_range(0, 9) == 0);
      end
      if (hold && c % 250 == 40) hold = 0;
      bus.s0_valid = ($urandom_range(0, 99) < 20);
      bus.s0_data = 8'($urandom);
      bus.s1_valid = ($urandom_range(0, 99) < 30);
      bus.s1_data = 8'($urandom);
      bus.overflow_clr = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle_inputs(); hold = 0;
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/debug_uart_tx_arbiter.md
Name: debug_uart_tx_arbiter

Overview:
- Shares the single debug UART transmitter (uart_tx start/busy handshake) between two byte sources.
- Source 0 is CPU writes to the debug UART address; source 1 is a hardware trace/dump stream, e.g. register-writeback bytes.
- Each source has a small FIFO. A round-robin scheduler drains the FIFOs into the transmitter, one byte per UART frame.
- Sits between the tinyQV data bus decode and the uart_tx instance. It replaces the direct tx_start wiring and supplies the busy/status bit for the UART status register.

Parameters:
- FIFO_DEPTH, 4, entries per source FIFO; power of two, 2..16.
- BUSY_TIMEOUT, 3, cycles to wait for tx_busy to rise after a start pulse before the byte is treated as sent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s0_valid  in  1  CPU byte write strobe, single cycle
- s0_data  in  8  CPU byte
- s0_full  out  1  source-0 FIFO full
- s1_valid  in  1  trace byte valid (valid/ready)
- s1_data  in  8  trace byte
- s1_ready  out  1  source-1 FIFO can accept
- tx_en  out  1  start pulse to uart_tx
- tx_data  out  8  byte to uart_tx, stable while tx_en=1
- tx_busy  in  1  uart_tx busy
- status_busy  out  1  any FIFO non-empty, or transfer in progress
- overflow  out  1  sticky: s0 write dropped while full
- overflow_clr  in  1  clears overflow
- s0_level  out  $clog2(FIFO_DEPTH)+1  source-0 occupancy

Behaviour:
Reset:
- Reset is asynchronous, active-low.
- All FIFOs empty, FSM=IDLE, priority pointer=source 0.
- tx_en=0, tx_data=0, overflow=0, s0_full=0, s1_ready=1, status_busy=0, s0_level=0.

FIFOs:
- Each source has its own circular FIFO. Read/write pointers are one bit wider than the index; full/empty come from the MSB comparison.
- s0: write when s0_valid=1 and not full. If s0_valid=1 while full, the byte is dropped and overflow is set.
- s1: write when s1_valid && s1_ready; s1_ready = !full. Source 1 never overflows.
- Simultaneous write and pop on the same FIFO is legal. Level is unchanged; this works even when the FIFO is full, since the pop frees a slot in the same cycle.
- overflow_clr and a new overflow in the same cycle: overflow stays 1 (set wins).

FSM states:
- IDLE:
  - If one FIFO is non-empty, grant it.
  - If both are non-empty, grant the source named by the priority pointer.
  - On grant: pop the head into a tx_data register and go to START.
- START:
  - tx_en=1 for exactly one cycle, then go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, go to IDLE; the byte is considered consumed.
- WAIT_DONE:
  - tx_busy=0: go to IDLE.
  - The priority pointer is set to the other source than the one just served.
  - The timeout exit from WAIT_BUSY updates the pointer the same way.

Timing and outputs:
- Minimum latency from an s0_valid write into an idle empty FIFO to tx_en is 2 cycles: write cycle, then IDLE grant/pop, then START.
- tx_data holds its value from START until the next grant.
- status_busy = (state != IDLE) || either FIFO non-empty. It is combinational, suitable for the read mux.
- Back-to-back bytes from one source alternate with the other source whenever both have data; there is no starvation.
- If tx_busy is already high in IDLE (e.g. held over from another user), no grant is made until it is low.

Test Plan:
- Reset mid-transfer: assert rst_n=0 while in WAIT_DONE with 2 bytes queued → all outputs return to reset values immediately; after release, no tx_en occurs.
- Single CPU byte: s0_valid with 0x41, uart model busy from cycle+1 for 10 cycles → tx_en pulses exactly once, 2 cycles after the write, with tx_data=0x41; status_busy is 1 until busy falls, then 0.
- Round-robin: preload s0 with {0x10,0x11} and s1 with {0x20,0x21} → tx_data order is 0x10,0x20,0x11,0x21.
- Overflow: with the UART held busy, 5 s0 writes 0x01..0x05 at FIFO_DEPTH=4 → s0_full=1 after the 4th write, overflow=1 after the 5th; 0x05 is never transmitted. overflow_clr then clears the flag.
- Backpressure: with s1_valid held high and the FIFO full, s1_ready=0 and the data is held → no byte lost, and the order is preserved across 8 bytes.
- Timeout: tx_busy tied 0 → each tx_en is followed by a return to IDLE after 3 cycles; 4 queued bytes drain with a period of 1+1+3 cycles.
